// File: rtl/cpu_datapath_p_if.sv
// cpu_datapath_p_if: memory bus and multiplier handshake between the datapath and its controller.
// master is the datapath side; slave is the memory/sequencer side.
interface cpu_datapath_p_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] i_mem_rddata;
    logic [WIDTH-1:0] o_mem_addr;
    logic [WIDTH-1:0] o_mem_wrdata;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;

    modport master (
        input  i_mem_rddata, mul_start,
        output o_mem_addr, o_mem_wrdata, mul_busy, mul_done
    );

    modport slave (
        output i_mem_rddata, mul_start,
        input  o_mem_addr, o_mem_wrdata, mul_busy, mul_done
    );
endinterface

// File: rtl/cpu_datapath_p.sv
// cpu_datapath_p: GPR file, A/S/PC/IR/ADDR/WRDATA registers, 4-op ALU with flags.
// Define CPU_DATAPATH_P_MUL_EN to build the shift-add multiplier and its M register (bus source 7).
module cpu_datapath_p #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned PC_STEP = 2
) (
    input  logic                clk,
    input  logic                reset,
    cpu_datapath_p_if.master    io,
    input  logic [2:0]          sel,
    input  logic [1:0]          alu_op,
    input  logic                pc_incr,
    input  logic [NREGS+6:0]    r_enable,
    output logic [WIDTH-1:0]    instruction,
    output logic                N,
    output logic                Z,
    output logic                C,
    output logic                V
);
    localparam int unsigned RB     = $clog2(NREGS);
    localparam int unsigned E_A    = NREGS;
    localparam int unsigned E_S    = NREGS + 1;
    localparam int unsigned E_F    = NREGS + 2;
    localparam int unsigned E_IR   = NREGS + 3;
    localparam int unsigned E_ADDR = NREGS + 4;
    localparam int unsigned E_WR   = NREGS + 5;
    localparam int unsigned E_PC   = NREGS + 6;

    logic [WIDTH-1:0] gpr [NREGS];
    logic [WIDTH-1:0] a, s, pc, addr_q, wrdata_q;
    logic [WIDTH-1:0] bus_val, sel7_val, imm8, imm11;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [RB-1:0]    rx, ry;

    assign rx    = instruction[5 +: RB];
    assign ry    = instruction[5+RB +: RB];
    assign imm8  = {{8{instruction[WIDTH-1]}}, instruction[WIDTH-1:8]};
    // The left shift is part of imm11 itself; bus source 5 applies no further shift.
    assign imm11 = {{4{instruction[WIDTH-1]}}, instruction[WIDTH-1:5], 1'b0};

    always_comb begin
        bus_val = '0;
        unique case (sel)
            3'd0:    bus_val = gpr[rx];
            3'd1:    bus_val = gpr[ry];
            3'd2:    bus_val = pc;
            3'd3:    bus_val = s;
            3'd4:    bus_val = imm8;
            3'd5:    bus_val = imm11;
            3'd6:    bus_val = io.i_mem_rddata;
            default: bus_val = sel7_val;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (alu_op)
            2'b00: begin
                {alu_c, alu_res} = {1'b0, a} + {1'b0, bus_val};
                alu_v = (a[WIDTH-1] == bus_val[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
                alu_res = a - bus_val;
                alu_c   = (a >= bus_val);
                alu_v   = (a[WIDTH-1] != bus_val[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10:   alu_res = a & bus_val;
            default: alu_res = a ^ bus_val;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) gpr[i] <= '0;
            a           <= '0;
            s           <= '0;
            pc          <= '0;
            instruction <= '0;
            addr_q      <= '0;
            wrdata_q    <= '0;
            N           <= 1'b0;
            Z           <= 1'b0;
            C           <= 1'b0;
            V           <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++)
                if (r_enable[i]) gpr[i] <= bus_val;
            if (r_enable[E_A])    a           <= bus_val;
            if (r_enable[E_S])    s           <= alu_res;
            if (r_enable[E_IR])   instruction <= io.i_mem_rddata;
            if (r_enable[E_ADDR]) addr_q      <= bus_val;
            if (r_enable[E_WR])   wrdata_q    <= bus_val;
            if (r_enable[E_F]) begin
                N <= alu_res[WIDTH-1];
                Z <= (alu_res == '0);
                C <= alu_c;
                V <= alu_v;
            end
            if (r_enable[E_PC])   pc <= bus_val;
            else if (pc_incr)     pc <= pc + WIDTH'(PC_STEP);
        end
    end

    assign io.o_mem_addr   = addr_q;
    assign io.o_mem_wrdata = wrdata_q;

`ifdef CPU_DATAPATH_P_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t       state;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_step, m_reg;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q;

    // Operands are private copies, so A/GPR writes mid-multiply cannot disturb the product.
    assign acc_step = mplier[0] ? acc + mcand : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            m_reg  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (io.mul_start) begin
                        mcand  <= a;
                        mplier <= bus_val;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        m_reg  <= acc_step;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign io.mul_busy = busy_q;
    assign io.mul_done = done_q;
    assign sel7_val    = m_reg;
`else
    assign io.mul_busy = 1'b0;
    assign io.mul_done = 1'b0;
    assign sel7_val    = io.i_mem_rddata;
`endif

endmodule

// File: tb/tb_cpu_datapath_p.sv
// tb_cpu_datapath_p: randomized and directed checks of cpu_datapath_p against an arithmetic reference model.
// Multiplier scenarios are selected by CPU_DATAPATH_P_MUL_EN, matching the RTL build.
module tb_cpu_datapath_p;
    localparam logic [14:0] EN_A = 15'h0100, EN_S = 15'h0200, EN_F = 15'h0400, EN_IR = 15'h0800;
    localparam logic [14:0] EN_ADDR = 15'h1000, EN_WR = 15'h2000, EN_PC = 15'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  sel;
    logic [1:0]  alu_op;
    logic        pc_incr;
    logic [14:0] r_enable;
    logic [15:0] instr16;
    logic        n16, z16, c16, v16;

    logic [2:0]  w_sel;
    logic [1:0]  w_op;
    logic        w_inc;
    logic [22:0] w_en;
    logic [31:0] w_instr;
    logic        w_n, w_z, w_c, w_v;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_gpr [8];
    int unsigned m_a, m_s, m_pc, m_ir, m_addr, m_wr, m_m;
    bit          m_n, m_z, m_c, m_v;

    always #5 clk = ~clk;

    cpu_datapath_p_if #(.WIDTH(16)) io16 ();
    cpu_datapath_p_if #(.WIDTH(32)) io32 ();

    cpu_datapath_p #(.WIDTH(16), .NREGS(8), .PC_STEP(2)) dut (
        .clk(clk), .reset(reset), .io(io16), .sel(sel), .alu_op(alu_op), .pc_incr(pc_incr),
        .r_enable(r_enable), .instruction(instr16), .N(n16), .Z(z16), .C(c16), .V(v16)
    );

    cpu_datapath_p #(.WIDTH(32), .NREGS(16), .PC_STEP(2)) dut_wide (
        .clk(clk), .reset(reset), .io(io32), .sel(w_sel), .alu_op(w_op), .pc_incr(w_inc),
        .r_enable(w_en), .instruction(w_instr), .N(w_n), .Z(w_z), .C(w_c), .V(w_v)
    );

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_gpr[i] = 0;
        m_a = 0; m_s = 0; m_pc = 0; m_ir = 0; m_addr = 0; m_wr = 0; m_m = 0;
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    endfunction

    // One clock edge of the 16-bit datapath expressed as plain integer arithmetic.
    function automatic void model_edge(input int unsigned s, input int unsigned op, input bit inc,
                                       input logic [14:0] en, input int unsigned rd);
        int unsigned b, res, fld;
        int sa, sb, sr;
        bit c, v;
        case (s)
            0: b = m_gpr[(m_ir / 32) % 8];
            1: b = m_gpr[(m_ir / 256) % 8];
            2: b = m_pc;
            3: b = m_s;
            4: begin fld = m_ir / 256; b = (fld >= 128) ? fld + 'hFF00 : fld; end
            5: begin fld = m_ir / 32; if (fld >= 1024) fld = fld + 'hF800; b = (fld * 2) % 65536; end
            6: b = rd;
`ifdef CPU_DATAPATH_P_MUL_EN
            default: b = m_m;
`else
            default: b = rd;
`endif
        endcase
        sa = (m_a >= 32768) ? int'(m_a) - 65536 : int'(m_a);
        sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
        c = 0; v = 0;
        case (op)
            0: begin res = m_a + b; c = (res >= 65536); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            1: begin res = m_a + 65536 - b; c = (m_a >= b); sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            2: res = m_a & b;
            default: res = m_a ^ b;
        endcase
        res = res % 65536;
        for (int i = 0; i < 8; i++) if (en[i]) m_gpr[i] = b;
        if (en[8])  m_a = b;
        if (en[9])  m_s = res;
        if (en[10]) begin m_n = (res >= 32768); m_z = (res == 0); m_c = c; m_v = v; end
        if (en[11]) m_ir = rd;
        if (en[12]) m_addr = b;
        if (en[13]) m_wr = b;
        if (en[14]) m_pc = b;
        else if (inc) m_pc = (m_pc + 2) % 65536;
    endfunction

    task automatic cycle(input logic [2:0] s, input logic [1:0] op, input logic inc,
                         input logic [14:0] en, input logic [15:0] rd, input logic start);
        sel = s; alu_op = op; pc_incr = inc; r_enable = en;
        io16.i_mem_rddata = rd; io16.mul_start = start;
        model_edge(s, op, inc, en, rd);
        @(posedge clk); #1;
    endtask

    task automatic w_cycle(input logic [2:0] s, input logic [22:0] en, input logic [31:0] rd);
        w_sel = s; w_en = en; io32.i_mem_rddata = rd;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (instr16 !== 16'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", instr16); end
        n_checks++; if (io16.o_mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", io16.o_mem_addr); end
        n_checks++; if (io16.o_mem_wrdata !== 16'h0) begin n_fail++; $display("FAIL reset_wr: got %h want 0000", io16.o_mem_wrdata); end
        n_checks++; if ({n16, z16, c16, v16} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {n16, z16, c16, v16}); end
        n_checks++; if ({io16.mul_busy, io16.mul_done} !== 2'b00) begin n_fail++; $display("FAIL reset_mul: got %b want 00", {io16.mul_busy, io16.mul_done}); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        cycle(3'd6, 2'd0, 1'b0, EN_ADDR, 16'hA5C3, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'hA5C3) begin n_fail++; $display("FAIL first_edge: got %h want a5c3", io16.o_mem_addr); end
        cycle(3'd2, 2'd0, 1'b0, EN_WR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_wrdata !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", io16.o_mem_wrdata); end
    endtask

    task automatic test_alu_flags();
        cycle(3'd6, 2'd0, 1'b0, EN_A, 16'h7FFF, 1'b0);
        cycle(3'd6, 2'b00, 1'b0, EN_S | EN_F, 16'h0001, 1'b0);
        n_checks++; if ({n16, z16, c16, v16} !== 4'b1001) begin n_fail++; $display("FAIL add_ovf_flags: got %b want 1001", {n16, z16, c16, v16}); end
        cycle(3'd3, 2'd0, 1'b0, EN_ADDR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'h8000) begin n_fail++; $display("FAIL add_ovf_s: got %h want 8000", io16.o_mem_addr); end
        cycle(3'd6, 2'd0, 1'b0, EN_A, 16'h0003, 1'b0);
        cycle(3'd6, 2'b01, 1'b0, EN_S | EN_F, 16'h0005, 1'b0);
        n_checks++; if ({n16, z16, c16, v16} !== 4'b1000) begin n_fail++; $display("FAIL sub_borrow_flags: got %b want 1000", {n16, z16, c16, v16}); end
        cycle(3'd3, 2'd0, 1'b0, EN_ADDR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL sub_borrow_s: got %h want fffe", io16.o_mem_addr); end
        cycle(3'd6, 2'd0, 1'b0, EN_A, 16'h0005, 1'b0);
        cycle(3'd6, 2'b01, 1'b0, EN_S | EN_F, 16'h0005, 1'b0);
        n_checks++; if ({n16, z16, c16, v16} !== 4'b0110) begin n_fail++; $display("FAIL sub_equal_flags: got %b want 0110", {n16, z16, c16, v16}); end
    endtask

    task automatic test_pc();
        cycle(3'd6, 2'd0, 1'b0, EN_PC, 16'hFFFE, 1'b0);
        cycle(3'd0, 2'd0, 1'b1, 15'h0, 16'h0, 1'b0);
        cycle(3'd2, 2'd0, 1'b0, EN_ADDR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'h0000) begin n_fail++; $display("FAIL pc_wrap: got %h want 0000", io16.o_mem_addr); end
        cycle(3'd6, 2'd0, 1'b1, EN_PC, 16'h1234, 1'b0);
        cycle(3'd2, 2'd0, 1'b1, EN_WR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_wrdata !== 16'h1234) begin n_fail++; $display("FAIL pc_load_priority: got %h want 1234", io16.o_mem_wrdata); end
        cycle(3'd2, 2'd0, 1'b0, EN_ADDR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'h1236) begin n_fail++; $display("FAIL pc_step: got %h want 1236", io16.o_mem_addr); end
    endtask

`ifdef CPU_DATAPATH_P_MUL_EN
    task automatic test_mul();
        int unsigned ma = 'h12, mb = 'h34, prod;
        int nb, nd;
        cycle(3'd6, 2'd0, 1'b0, EN_A, 16'(ma), 1'b0);
        cycle(3'd6, 2'd0, 1'b0, 15'h0, 16'(mb), 1'b1);
        nb = int'(io16.mul_busy); nd = int'(io16.mul_done);
        for (int i = 0; i < 30; i++) begin
            cycle(3'd6, 2'd0, 1'b0, (i == 4) ? EN_A : 15'h0, 16'hFFFF, i == 2);
            nb += int'(io16.mul_busy); nd += int'(io16.mul_done);
        end
        prod = (ma * mb) % 65536;
        m_m = prod;
        n_checks++; if (nb != 16) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 16", nb); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL mul_done_pulses: got %0d want 1", nd); end
        cycle(3'd7, 2'd0, 1'b0, EN_ADDR, 16'hDEAD, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'(prod)) begin n_fail++; $display("FAIL mul_product: got %h want %h", io16.o_mem_addr, 16'(prod)); end
    endtask

    task automatic test_mul_reset();
        int unsigned ma, mb, prod;
        bit got_done;
        cycle(3'd6, 2'd0, 1'b0, EN_A, 16'h0007, 1'b0);
        cycle(3'd6, 2'd0, 1'b0, 15'h0, 16'h0009, 1'b1);
        repeat (4) cycle(3'd0, 2'd0, 1'b0, 15'h0, 16'h0, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if ({io16.mul_busy, io16.mul_done} !== 2'b00) begin n_fail++; $display("FAIL midmul_reset_mul: got %b want 00", {io16.mul_busy, io16.mul_done}); end
        n_checks++; if ({io16.o_mem_addr, io16.o_mem_wrdata, instr16} !== 48'h0) begin n_fail++; $display("FAIL midmul_reset_regs: got %h want 0", {io16.o_mem_addr, io16.o_mem_wrdata, instr16}); end
        @(negedge clk);
        reset = 1'b1;
        cycle(3'd7, 2'd0, 1'b0, EN_ADDR, 16'hBEEF, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'h0) begin n_fail++; $display("FAIL midmul_reset_m: got %h want 0000", io16.o_mem_addr); end
        ma = $urandom % 65536; mb = $urandom % 65536;
        cycle(3'd6, 2'd0, 1'b0, EN_A, 16'(ma), 1'b0);
        cycle(3'd6, 2'd0, 1'b0, 15'h0, 16'(mb), 1'b1);
        got_done = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            cycle(3'd0, 2'd0, 1'b0, 15'h0, 16'h0, 1'b0);
            if (io16.mul_done === 1'b1) got_done = 1;
        end
        n_checks++; if (!got_done) begin n_fail++; $display("FAIL fresh_mul_done: got timeout want done"); end
        prod = (ma * mb) % 65536;
        m_m = prod;
        cycle(3'd7, 2'd0, 1'b0, EN_ADDR, 16'h0, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'(prod)) begin n_fail++; $display("FAIL fresh_mul_product: got %h want %h", io16.o_mem_addr, 16'(prod)); end
    endtask
`else
    task automatic test_mul_disabled();
        int nb = 0, nd = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(3'd0, 2'd0, 1'b0, 15'h0, 16'h0, 1'b1);
            nb += int'(io16.mul_busy); nd += int'(io16.mul_done);
        end
        n_checks++; if (nb + nd != 0) begin n_fail++; $display("FAIL nomul_handshake: got %0d want 0", nb + nd); end
        cycle(3'd7, 2'd0, 1'b0, EN_ADDR, 16'h5A5A, 1'b0);
        n_checks++; if (io16.o_mem_addr !== 16'h5A5A) begin n_fail++; $display("FAIL nomul_sel7: got %h want 5a5a", io16.o_mem_addr); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            cycle(3'($urandom_range(0, 7)), 2'($urandom), 1'($urandom), 15'($urandom), 16'($urandom), 1'b0);
            n_checks++; if (io16.o_mem_addr !== 16'(m_addr)) begin n_fail++; $display("FAIL rand_addr[%0d]: got %h want %h", i, io16.o_mem_addr, 16'(m_addr)); end
            n_checks++; if (io16.o_mem_wrdata !== 16'(m_wr)) begin n_fail++; $display("FAIL rand_wr[%0d]: got %h want %h", i, io16.o_mem_wrdata, 16'(m_wr)); end
            n_checks++; if (instr16 !== 16'(m_ir)) begin n_fail++; $display("FAIL rand_ir[%0d]: got %h want %h", i, instr16, 16'(m_ir)); end
            n_checks++; if ({n16, z16, c16, v16} !== {m_n, m_z, m_c, m_v}) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {n16, z16, c16, v16}, {m_n, m_z, m_c, m_v}); end
        end
    endtask

    task automatic test_wide();
        logic signed [31:0] ir_s;
        logic [31:0] ir, val, exp11, exp8;
        ir = 32'h80001FE0;
        ir_s = ir;
        val = $urandom;
        exp11 = (ir_s >>> 5) << 1;
        exp8  = ir_s >>> 8;
        w_cycle(3'd6, 23'h080000, ir);
        n_checks++; if (w_instr !== ir) begin n_fail++; $display("FAIL wide_ir: got %h want %h", w_instr, ir); end
        w_cycle(3'd6, 23'h008000, val);
        w_cycle(3'd0, 23'h100000, 32'h0);
        n_checks++; if (io32.o_mem_addr !== val) begin n_fail++; $display("FAIL wide_r15_rx: got %h want %h", io32.o_mem_addr, val); end
        w_cycle(3'd1, 23'h100000, 32'h0);
        n_checks++; if (io32.o_mem_addr !== val) begin n_fail++; $display("FAIL wide_r15_ry: got %h want %h", io32.o_mem_addr, val); end
        w_cycle(3'd5, 23'h100000, 32'h0);
        n_checks++; if (io32.o_mem_addr !== exp11) begin n_fail++; $display("FAIL wide_imm11: got %h want %h", io32.o_mem_addr, exp11); end
        w_cycle(3'd4, 23'h100000, 32'h0);
        n_checks++; if (io32.o_mem_addr !== exp8) begin n_fail++; $display("FAIL wide_imm8: got %h want %h", io32.o_mem_addr, exp8); end
    endtask

    initial begin
        reset = 1'b0;
        sel = '0; alu_op = '0; pc_incr = 1'b0; r_enable = '0;
        io16.i_mem_rddata = '0; io16.mul_start = 1'b0;
        w_sel = '0; w_op = '0; w_inc = 1'b0; w_en = '0;
        io32.i_mem_rddata = '0; io32.mul_start = 1'b0;
        model_reset();
        test_reset();
        test_alu_flags();
        test_pc();
`ifdef CPU_DATAPATH_P_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        test_random();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
